// File: rtl/mux_slot_demux_pkg.sv
// Shared constants and state encoding for the mux slot demultiplexer and its
// settle timer.
package mux_slot_demux_pkg;

  localparam int SLOT_COUNT     = 4;
  localparam int SETTLE_DEFAULT = 3;
  localparam int CNT_W          = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SLOT = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mux_slot_demux_if.sv
// Bundle between the mux/control side (master) and the slot demultiplexer
// (slave), including the FSM state for observation.
interface mux_slot_demux_if #(
  parameter int WIDTH = 2
);
  import mux_slot_demux_pkg::*;

  // start is a level request seen only while idle; a request arriving while
  // busy is dropped, not queued. done is a single-cycle pulse meaning
  // outA..outD hold a fresh, complete scan; they stay stable until the next one.
  logic             start;
  logic [WIDTH-1:0] busIn;
  logic [1:0]       sel;
  logic [1:0]       notIE;
  logic [WIDTH-1:0] outA;
  logic [WIDTH-1:0] outB;
  logic [WIDTH-1:0] outC;
  logic [WIDTH-1:0] outD;
  logic             busy;
  logic             done;
  state_e           state;

  modport master (
    output start, busIn,
    input  sel, notIE, outA, outB, outC, outD, busy, done, state
  );

  modport slave (
    input  start, busIn,
    output sel, notIE, outA, outB, outC, outD, busy, done, state
  );

endinterface

// File: rtl/mux_slot_settle_timer.sv
// Loadable down-counter with a zero flag; used to wait out 74xx-style
// propagation/settle delays.
module mux_slot_settle_timer
  import mux_slot_demux_pkg::*;
(
  input  logic             clk,
  input  logic             notReset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] value_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Load wins over decrement; the counter parks at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = value_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge notReset) begin
    if (!notReset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mux_slot_demux.sv
// Scans the four slots of a dual 4-to-1 mux, sampling each after a settle
// delay, and publishes all four values together with a done pulse.
module mux_slot_demux
  import mux_slot_demux_pkg::*;
#(
  parameter int WIDTH  = 2,
  parameter int SETTLE = SETTLE_DEFAULT
) (
  input logic              clk,
  input logic              notReset,
  mux_slot_demux_if.slave  bus
);

  localparam logic [CNT_W-1:0] SETTLE_CNT = CNT_W'(SETTLE);
  localparam logic [1:0]       SLOT_LAST  = 2'(SLOT_COUNT - 1);

  state_e           state_q;
  logic [1:0]       sel_q;
  logic [1:0]       notie_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] outa_q, outb_q, outc_q, outd_q;
  logic [WIDTH-1:0] shadow_q [SLOT_COUNT];
  logic [WIDTH-1:0] shadow_d [SLOT_COUNT];

  logic cnt_zero;
  logic cnt_load;
  logic cnt_dec;
  logic sample;

  assign sample   = (state_q == SLOT) && cnt_zero;
  assign cnt_load = ((state_q == IDLE) && bus.start) || (sample && (sel_q != SLOT_LAST));
  assign cnt_dec  = (state_q == SLOT) && !cnt_zero;

  mux_slot_settle_timer u_timer (
    .clk      (clk),
    .notReset (notReset),
    .load_i   (cnt_load),
    .value_i  (SETTLE_CNT),
    .dec_i    (cnt_dec),
    .zero_o   (cnt_zero)
  );

  // The publish copy reads shadow_d so the slot written on the final edge is included.
  always_comb begin
    shadow_d = shadow_q;
    if (sample) begin
      shadow_d[sel_q] = bus.busIn;
    end
  end

  always_ff @(posedge clk or negedge notReset) begin
    if (!notReset) begin
      state_q <= IDLE;
      sel_q   <= 2'd0;
      notie_q <= 2'b11;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      outa_q  <= '0;
      outb_q  <= '0;
      outc_q  <= '0;
      outd_q  <= '0;
      for (int i = 0; i < SLOT_COUNT; i++) begin
        shadow_q[i] <= '0;
      end
    end else begin
      shadow_q <= shadow_d;
      done_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q <= SLOT;
            sel_q   <= 2'd0;
            notie_q <= 2'b00;
            busy_q  <= 1'b1;
          end
        end
        SLOT: begin
          if (cnt_zero) begin
            if (sel_q == SLOT_LAST) begin
              state_q <= DONE;
              outa_q  <= shadow_d[0];
              outb_q  <= shadow_d[1];
              outc_q  <= shadow_d[2];
              outd_q  <= shadow_d[3];
              done_q  <= 1'b1;
              notie_q <= 2'b11;
            end else begin
              sel_q <= sel_q + 2'd1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          sel_q   <= 2'd0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.sel   = sel_q;
  assign bus.notIE = notie_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.outA  = outa_q;
  assign bus.outB  = outb_q;
  assign bus.outC  = outc_q;
  assign bus.outD  = outd_q;
  assign bus.state = state_q;

endmodule

// File: tb/tb_mux_slot_demux.sv
// Bench for mux_slot_demux: three instances (SETTLE 3, 1, 0) each fed by a
// slow-settling mux model, checked cycle by cycle against a scoreboard.
module tb_mux_slot_demux;
  import mux_slot_demux_pkg::*;

  localparam int NI = 3;
  localparam int SETTLE_TAB [NI] = '{3, 1, 0};

  // clock / reset
  logic clk      = 1'b0;
  logic notReset = 1'b1;
  always #5 clk = ~clk;

  logic [NI-1:0]      start_r  = '0;
  logic [NI-1:0][7:0] mux_data = '0;   // {slot0, slot1, slot2, slot3}
  logic [NI-1:0]      busy_w, done_w;
  logic [NI-1:0][1:0] sel_w, notie_w;
  logic [NI-1:0][7:0] pub_w;           // {outA, outB, outC, outD}

  for (genvar g = 0; g < NI; g++) begin : g_inst
    mux_slot_demux_if #(.WIDTH(2)) bus ();

    logic [1:0] bus_val  = 2'b00;
    int         age      = 0;
    logic [3:0] last_key = 4'hF;

    // Mux model: correct data appears 3 cycles after the select/enable
    // changes; before that it drives the complement.
    always @(negedge clk) begin : mux_model
      int         age_n;
      logic [1:0] good;
      good  = 2'((mux_data[g] >> (6 - 2 * int'(bus.sel))) & 8'h03);
      age_n = ({bus.notIE, bus.sel} != last_key) ? 0 : ((age < 15) ? age + 1 : age);
      age      <= age_n;
      last_key <= {bus.notIE, bus.sel};
      if (bus.notIE != 2'b00) bus_val <= 2'b00;
      else                    bus_val <= (age_n >= 3) ? good : ~good;
    end

    assign bus.start = start_r[g];
    assign bus.busIn = bus_val;
    assign busy_w[g]  = bus.busy;
    assign done_w[g]  = bus.done;
    assign sel_w[g]   = bus.sel;
    assign notie_w[g] = bus.notIE;
    assign pub_w[g]   = {bus.outA, bus.outB, bus.outC, bus.outD};

    mux_slot_demux #(.WIDTH(2), .SETTLE(SETTLE_TAB[g])) dut (
      .clk      (clk),
      .notReset (notReset),
      .bus      (bus)
    );
  end

  // scoreboard: {instance, published value}
  logic [9:0] exp_q[$];
  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;
  int   accept    [NI] = '{default: 0};
  int   busy_len  [NI] = '{default: 0};
  int   done_cnt  [NI] = '{default: 0};
  logic busy_prev [NI] = '{default: 1'b0};
  logic done_prev [NI] = '{default: 1'b0};
  logic [7:0] last_pub [NI] = '{default: 8'h00};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic monitor(input int k);
    int         per;
    logic [9:0] e;
    per = SETTLE_TAB[k] + 1;
    if (busy_w[k] && !busy_prev[k]) begin
      accept[k]   = cyc;
      busy_len[k] = 0;
    end
    if (busy_w[k]) begin
      busy_len[k]++;
      if (done_w[k]) begin
        check($sformatf("done_single[%0d]", k), done_prev[k], 0);
        check($sformatf("done_latency[%0d]", k), cyc - accept[k], 4 * per);
        check($sformatf("sel_in_done[%0d]", k), sel_w[k], 3);
        check($sformatf("notie_in_done[%0d]", k), notie_w[k], 2'b11);
        if (exp_q.size() == 0) begin
          check($sformatf("sb_nonempty[%0d]", k), exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("sb_slot[%0d]", k), e[9:8], k);
          check($sformatf("published[%0d]", k), pub_w[k], e[7:0]);
          last_pub[k] = e[7:0];
        end
        done_cnt[k]++;
      end else begin
        check($sformatf("sel_step[%0d]", k), sel_w[k], (cyc - accept[k]) / per);
        check($sformatf("notie_scan[%0d]", k), notie_w[k], 2'b00);
        check($sformatf("atomic_hold[%0d]", k), pub_w[k], last_pub[k]);
      end
    end else begin
      if (busy_prev[k]) check($sformatf("busy_len[%0d]", k), busy_len[k], 4 * per + 1);
      check($sformatf("idle_sel[%0d]", k), sel_w[k], 0);
      check($sformatf("idle_notie[%0d]", k), notie_w[k], 2'b11);
      check($sformatf("idle_done[%0d]", k), done_w[k], 0);
      check($sformatf("idle_hold[%0d]", k), pub_w[k], last_pub[k]);
    end
    busy_prev[k] = busy_w[k];
    done_prev[k] = done_w[k];
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    for (int k = 0; k < NI; k++) monitor(k);
  endtask

  task automatic pulse_start(input int k);
    start_r[k] = 1'b1;
    tick();
    start_r[k] = 1'b0;
  endtask

  task automatic run_scan(input int k, input int budget);
    int target;
    target = done_cnt[k] + 1;
    for (int i = 0; i < budget && done_cnt[k] < target; i++) tick();
    check($sformatf("done_timeout[%0d]", k), done_cnt[k], target);
  endtask

  initial begin
    int saved;
    #1 notReset = 1'b0;
    repeat (2) tick();
    for (int k = 0; k < NI; k++) begin
      check($sformatf("reset_busy[%0d]", k), busy_w[k], 0);
      check($sformatf("reset_pub[%0d]", k), pub_w[k], 8'h00);
    end
    notReset = 1'b1;
    tick();

    // basic scan, SETTLE=3: 01/10/11/00
    mux_data[0] = 8'h6C;
    exp_q.push_back({2'd0, 8'h6C});
    pulse_start(0);
    run_scan(0, 40);
    repeat (3) tick();

    // SETTLE=1 samples before the mux settles: complemented data captured
    mux_data[1] = 8'h6C;
    exp_q.push_back({2'd1, 8'h93});
    pulse_start(1);
    run_scan(1, 40);
    repeat (3) tick();

    // atomic update with start held high across the scan
    mux_data[0] = 8'hFF;
    exp_q.push_back({2'd0, 8'hFF});
    exp_q.push_back({2'd0, 8'hFF});
    start_r[0] = 1'b1;
    run_scan(0, 40);
    tick();
    check("gap_idle", busy_w[0], 0);
    tick();
    check("gap_restart", busy_w[0], 1);
    start_r[0] = 1'b0;
    run_scan(0, 40);
    repeat (3) tick();

    // reset while sel=2 aborts the scan
    mux_data[0] = 8'h6C;
    exp_q.push_back({2'd0, 8'h6C});
    saved = done_cnt[0];
    pulse_start(0);
    for (int i = 0; i < 40 && sel_w[0] != 2'd2; i++) tick();
    check("reach_sel2", sel_w[0], 2);
    #2 notReset = 1'b0;
    #1;
    check("rst_sel", sel_w[0], 0);
    check("rst_notie", notie_w[0], 2'b11);
    check("rst_busy", busy_w[0], 0);
    check("rst_done", done_w[0], 0);
    check("rst_pub", pub_w[0], 8'h00);
    exp_q.delete();
    for (int k = 0; k < NI; k++) begin
      busy_prev[k] = 1'b0;
      done_prev[k] = 1'b0;
      last_pub[k]  = 8'h00;
    end
    repeat (3) tick();
    check("no_done_on_abort", done_cnt[0], saved);
    notReset = 1'b1;
    tick();
    exp_q.push_back({2'd0, 8'h6C});
    pulse_start(0);
    run_scan(0, 40);
    repeat (2) tick();

    // SETTLE=0: one cycle per slot, done 4 cycles after accept
    mux_data[2] = 8'h6C;
    exp_q.push_back({2'd2, 8'h93});
    pulse_start(2);
    run_scan(2, 20);
    repeat (3) tick();

    check("sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
